// File: rtl/spi_byte_slave_pkg.sv
// Shared types and constants for the SPI byte slave front end.
package spi_byte_slave_pkg;

  localparam int SPI_BYTE_BITS = 8;
  localparam int SPI_CNT_W     = 3;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_slave_state_t;

endpackage

// File: rtl/spi_byte_slave_sync.sv
// Multi-flop single-bit synchroniser with a configurable reset level.
module comms_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; reset to the idle pin level so no false edge is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 slave: synchronises the pins, assembles MOSI bytes and
// serialises the handler's transmit byte onto MISO, MSB first.
module spi_byte_slave
  import spi_byte_slave_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spi_sclk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic                     spi_rx_valid,
  output logic [SPI_BYTE_BITS-1:0] spi_rx_byte,
  input  logic [SPI_BYTE_BITS-1:0] spi_tx_byte,
  output logic                     spi_frame_active,
  output logic                     spi_frame_error
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d_r;
  logic rise_s, fall_s;

  logic [SETTLE_W-1:0] settle_r;
  logic                settled_s;
  logic                armed_r;

  spi_slave_state_t         state_r, state_nx;
  logic [SPI_CNT_W-1:0]     cnt_r, cnt_nx;
  logic [SPI_BYTE_BITS-1:0] rx_sh_r, rx_sh_nx;
  logic [SPI_BYTE_BITS-1:0] tx_sh_r, tx_sh_nx;
  logic [SPI_BYTE_BITS-1:0] rx_byte_r, rx_byte_nx;
  logic                     miso_r, miso_nx;
  logic                     oe_r, oe_nx;
  logic                     rx_valid_r, rx_valid_nx;
  logic                     err_r, err_nx;

  comms_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s)
  );
  comms_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s)
  );
  comms_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s)
  );

  // Delayed synchronised SCLK for one-cycle edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d_r <= 1'b0;
    end else begin
      sclk_d_r <= sclk_s;
    end
  end

  assign rise_s = sclk_s & ~sclk_d_r;
  assign fall_s = ~sclk_s & sclk_d_r;

  // The synchroniser reset level is not a real observation of the pin, so
  // the FSM is armed only after a genuine high cs_n has passed through it.
  // This keeps a CS held low across reset from resuming a partial frame.
  assign settled_s = (settle_r == SETTLE_W'(SYNC_STAGES));

  // Settle counter and arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_r <= '0;
      armed_r  <= 1'b0;
    end else begin
      if (!settled_s) begin
        settle_r <= settle_r + SETTLE_W'(1);
      end
      if (settled_s && cs_n_s) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Next-state and datapath updates for the frame FSM.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    rx_sh_nx    = rx_sh_r;
    tx_sh_nx    = tx_sh_r;
    rx_byte_nx  = rx_byte_r;
    miso_nx     = miso_r;
    oe_nx       = oe_r;
    rx_valid_nx = 1'b0;
    err_nx      = 1'b0;
    case (state_r)
      SPI_IDLE: begin
        if (armed_r && !cs_n_s) begin
          state_nx = SPI_ACTIVE;
          cnt_nx   = '0;
          tx_sh_nx = spi_tx_byte;
          miso_nx  = spi_tx_byte[SPI_BYTE_BITS-1];
          oe_nx    = 1'b1;
        end else begin
          miso_nx  = IDLE_MISO;
          oe_nx    = 1'b0;
        end
      end
      SPI_ACTIVE: begin
        if (cs_n_s) begin
          state_nx = SPI_IDLE;
          miso_nx  = IDLE_MISO;
          oe_nx    = 1'b0;
          err_nx   = (cnt_r != '0);
          cnt_nx   = '0;
        end else if (rise_s) begin
          rx_sh_nx = {rx_sh_r[SPI_BYTE_BITS-2:0], mosi_s};
          cnt_nx   = cnt_r + SPI_CNT_W'(1);
          if (cnt_r == SPI_CNT_W'(SPI_BYTE_BITS - 1)) begin
            rx_byte_nx  = {rx_sh_r[SPI_BYTE_BITS-2:0], mosi_s};
            rx_valid_nx = 1'b1;
          end else begin
            rx_valid_nx = 1'b0;
          end
        end else if (fall_s) begin
          // Counter at 0 on a fall marks the byte boundary: fetch a new byte.
          if (cnt_r == '0) begin
            tx_sh_nx = spi_tx_byte;
            miso_nx  = spi_tx_byte[SPI_BYTE_BITS-1];
          end else begin
            tx_sh_nx = {tx_sh_r[SPI_BYTE_BITS-2:0], 1'b0};
            miso_nx  = tx_sh_r[SPI_BYTE_BITS-2];
          end
        end else begin
          state_nx = SPI_ACTIVE;
        end
      end
      default: begin
        state_nx = SPI_IDLE;
        miso_nx  = IDLE_MISO;
        oe_nx    = 1'b0;
        cnt_nx   = '0;
      end
    endcase
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= SPI_IDLE;
      cnt_r      <= '0;
      rx_sh_r    <= '0;
      tx_sh_r    <= '0;
      rx_byte_r  <= '0;
      miso_r     <= IDLE_MISO;
      oe_r       <= 1'b0;
      rx_valid_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nx;
      cnt_r      <= cnt_nx;
      rx_sh_r    <= rx_sh_nx;
      tx_sh_r    <= tx_sh_nx;
      rx_byte_r  <= rx_byte_nx;
      miso_r     <= miso_nx;
      oe_r       <= oe_nx;
      rx_valid_r <= rx_valid_nx;
      err_r      <= err_nx;
    end
  end

  assign spi_miso         = miso_r;
  assign spi_miso_oe      = oe_r;
  assign spi_rx_valid     = rx_valid_r;
  assign spi_rx_byte      = rx_byte_r;
  assign spi_frame_active = (state_r == SPI_ACTIVE);
  assign spi_frame_error  = err_r;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Randomised bench for spi_byte_slave against a byte-level frame model.
module tb_spi_byte_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       spi_rx_valid;
  logic [7:0] spi_rx_byte;
  logic [7:0] spi_tx_byte = 8'h00;
  logic       spi_frame_active;
  logic       spi_frame_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mosi_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] got_q[$];
  logic       miso_q[$];
  int         err_seen = 0;
  int         both_seen = 0;
  int         oe_bad = 0;

  spi_byte_slave #(.SYNC_STAGES(2), .IDLE_MISO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .spi_rx_valid(spi_rx_valid), .spi_rx_byte(spi_rx_byte),
    .spi_tx_byte(spi_tx_byte), .spi_frame_active(spi_frame_active),
    .spi_frame_error(spi_frame_error)
  );

  always #5 clk = ~clk;

  // Observe handler-side pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (spi_rx_valid) got_q.push_back(spi_rx_byte);
      if (spi_frame_error) err_seen++;
      if (spi_rx_valid && spi_frame_error) both_seen++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Master side: nbits of mosi_q MSB first, one bit per 8 clk.
  task automatic shift_bits(input int nbits, input logic oe_exp);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_q[i/8][7-(i%8)];
      repeat (4) @(negedge clk);
      miso_q.push_back(spi_miso);
      if (spi_miso_oe !== oe_exp) oe_bad++;
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      if ((i % 8) == 7 && (i/8 + 1) < tx_q.size()) spi_tx_byte = tx_q[i/8 + 1];
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input int nbits);
    int e0;
    int nfull;
    logic [7:0] mb;
    got_q.delete();
    miso_q.delete();
    oe_bad = 0;
    e0 = err_seen;
    nfull = nbits / 8;
    spi_tx_byte = tx_q[0];
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    shift_bits(nbits, 1'b1);
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq({name, " rx_count"}, got_q.size(), nfull);
    for (int k = 0; k < nfull && k < got_q.size(); k++) begin
      check_eq({name, " rx_byte"}, got_q[k], mosi_q[k]);
      for (int b = 0; b < 8; b++) mb[7-b] = miso_q[8*k + b];
      check_eq({name, " miso_byte"}, mb, tx_q[k]);
    end
    if (nfull > 0) check_eq({name, " rx_hold"}, spi_rx_byte, mosi_q[nfull-1]);
    check_eq({name, " frame_error"}, err_seen - e0, ((nbits % 8) != 0) ? 1 : 0);
    check_eq({name, " oe_inside"}, oe_bad, 0);
    check_eq({name, " oe_after"}, spi_miso_oe, 1'b0);
    check_eq({name, " miso_idle"}, spi_miso, 1'b0);
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    check_eq("reset miso", spi_miso, 1'b0);
    check_eq("reset oe", spi_miso_oe, 1'b0);
    check_eq("reset valid", spi_rx_valid, 1'b0);
    check_eq("reset byte", spi_rx_byte, 8'h00);
    check_eq("reset active", spi_frame_active, 1'b0);
    check_eq("reset error", spi_frame_error, 1'b0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    mosi_q = '{8'hA5}; tx_q = '{8'h00};
    run_frame("a5", 8);

    mosi_q = '{8'h00}; tx_q = '{8'h3C};
    run_frame("tx3c", 8);

    mosi_q = '{8'h01, 8'hDE, 8'hAD}; tx_q = '{8'h12, 8'h77, 8'h9B};
    run_frame("b2b", 24);

    mosi_q = '{8'hB3}; tx_q = '{8'hF0};
    run_frame("partial", 5);
    mosi_q = '{8'h5A}; tx_q = '{8'h81};
    run_frame("after_partial", 8);

    // Reset in the middle of a byte with CS held low.
    mosi_q = '{8'hFF}; tx_q = '{8'hAA};
    spi_tx_byte = 8'hAA;
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    shift_bits(4, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst miso", spi_miso, 1'b0);
    check_eq("midrst oe", spi_miso_oe, 1'b0);
    check_eq("midrst byte", spi_rx_byte, 8'h00);
    check_eq("midrst active", spi_frame_active, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    nb = err_seen;
    repeat (6) @(negedge clk);
    oe_bad = 0;
    shift_bits(8, 1'b0);
    repeat (6) @(negedge clk);
    check_eq("postrst no_rx", got_q.size(), 0);
    check_eq("postrst active", spi_frame_active, 1'b0);
    check_eq("postrst oe", oe_bad, 0);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("postrst no_err", err_seen - nb, 0);
    mosi_q = '{8'hC3}; tx_q = '{8'h5C};
    run_frame("c3", 8);

    // SCLK activity with CS high must be ignored.
    got_q.delete();
    oe_bad = 0;
    for (int i = 0; i < 16; i++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      spi_sclk = ~spi_sclk;
      repeat (4) @(negedge clk);
      if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) oe_bad++;
    end
    spi_sclk = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("idle_sclk no_rx", got_q.size(), 0);
    check_eq("idle_sclk pins", oe_bad, 0);

    // Random frames, whole or partial.
    for (int f = 0; f < 8; f++) begin
      nb = $urandom_range(1, 3);
      mosi_q.delete(); tx_q.delete();
      for (int k = 0; k < nb; k++) begin
        mosi_q.push_back(8'($urandom_range(0, 255)));
        tx_q.push_back(8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 3) == 0) run_frame("rand_part", 8*(nb-1) + $urandom_range(1, 7));
      else run_frame("rand", 8*nb);
    end

    check_eq("valid_and_error", both_seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
